// File: rtl/cdc_src_flush_buffer.sv
// Source-side FIFO in front of the clearable CDC. It sequences local and far-side clears and counts the words they discard.
// One-cycle push-to-valid latency. A flush stalls both stream sides combinationally until the CDC clear handshake completes.
module cdc_src_flush_buffer #(
    parameter type         T         = logic [7:0],
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_req_i,
    output logic                 flush_busy_o,
    input  T                     in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output T                     cdc_data_o,
    output logic                 cdc_valid_o,
    input  logic                 cdc_ready_i,
    output logic                 cdc_clear_o,
    input  logic                 cdc_clear_pending_i,
    output logic [CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = ((CNT_WIDTH > CNT_W) ? CNT_WIDTH : CNT_W) + 1;

    typedef enum logic [1:0] {RUN, CLEAR, WAIT_RISE, WAIT_FALL} state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    T                     mem_q [DEPTH];
    logic [CNT_WIDTH-1:0] drop_cnt_q;
    logic [SUM_W-1:0]     drop_sum;
    logic                 flush, push, pop;

    // Either clear source empties the FIFO on the cycle it is first seen in RUN.
    assign flush = (state_q == RUN) && (cdc_clear_pending_i || flush_req_i);
    assign push  = in_valid_i && in_ready_o;
    assign pop   = cdc_valid_o && cdc_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (cdc_clear_pending_i) begin
                    state_d = WAIT_FALL;
                end else if (flush_req_i) begin
                    state_d = CLEAR;
                end
            end
            // A far-side clear racing our own is absorbed rather than overlapped.
            CLEAR:     state_d = cdc_clear_pending_i ? WAIT_FALL : WAIT_RISE;
            WAIT_RISE: if (cdc_clear_pending_i) state_d = WAIT_FALL;
            WAIT_FALL: if (!cdc_clear_pending_i) state_d = RUN;
            default:   state_d = RUN;
        endcase
    end

    always_comb begin
        in_ready_o   = 1'b0;
        cdc_valid_o  = 1'b0;
        cdc_clear_o  = 1'b0;
        flush_busy_o = 1'b1;
        case (state_q)
            RUN: begin
                flush_busy_o = 1'b0;
                in_ready_o   = !flush && (count_q < CNT_W'(DEPTH));
                cdc_valid_o  = !flush && (count_q != '0);
            end
            CLEAR:   cdc_clear_o = !cdc_clear_pending_i;
            default: ;
        endcase
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

    assign cdc_data_o = mem_q[rd_ptr_q];

    // Sum is computed one bit wider than either operand so saturation is a plain compare.
    assign drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(count_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else if (flush) begin
            drop_cnt_q <= (drop_sum > SUM_W'({CNT_WIDTH{1'b1}})) ? '1 : drop_sum[CNT_WIDTH-1:0];
        end
    end

    assign drop_cnt_o = drop_cnt_q;

endmodule
